// File: rtl/dqn_action_selector.sv
// dqn_action_selector: epsilon-greedy action picker for the 3x3 grid-world DQN.
// Explores with a random action from a 16-bit LFSR, or reads the four Q-values
// of the current state and returns the signed argmax (ties go to the lowest index).
// Epsilon decays linearly on each episode boundary, down to a floor.
module dqn_action_selector #(
    parameter int unsigned QW       = 16,
    parameter logic [7:0]  EPS_INIT = 8'd255,
    parameter logic [7:0]  EPS_MIN  = 8'd16,
    parameter logic [7:0]  EPS_DEC  = 8'd8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    st,
    input  logic          episode_done,
    output logic          q_rd,
    output logic [5:0]    q_addr,
    input  logic [QW-1:0] q_data,
    output logic [1:0]    act,
    output logic          act_valid,
    output logic          explore,
    output logic          busy,
    output logic [7:0]    epsilon
);

    // DONE is never resident: the edge leaving EXPL/DRAIN registers the result
    // and lands in IDLE directly, so act_valid coincides with the first IDLE cycle.
    typedef enum logic [2:0] {IDLE, EXPL, READ, DRAIN, DONE} state_t;

    state_t               state, state_nx;
    logic [15:0]          lfsr;
    logic [3:0]           st_l;
    logic                 accept, pick_rand, finish, finish_rand;
    logic                 cmp_valid;
    logic [1:0]           cmp_idx;
    logic signed [QW-1:0] best;
    logic [1:0]           best_a;
    logic                 take;
    logic [1:0]           final_a;

    assign busy      = (state != IDLE);
    assign pick_rand = (lfsr[7:0] < epsilon);
    // a=0 seeds the running best; later indices win only on strict signed greater-than.
    assign take      = cmp_valid && ((cmp_idx == 2'd0) || ($signed(q_data) > best));
    assign final_a   = take ? cmp_idx : best_a;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and one-cycle control decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        state_nx    = state;
        accept      = 1'b0;
        finish      = 1'b0;
        finish_rand = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = pick_rand ? EXPL : READ;
                end
            end
            EXPL: begin
                finish      = 1'b1;
                finish_rand = 1'b1;
                state_nx    = IDLE;
            end
            READ: begin
                if (q_addr[1:0] == 2'd3) state_nx = DRAIN;
            end
            DRAIN: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1; holds its seed in reset.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Q-table read sequencer: four consecutive addresses {st_l, a}, a = 0..3.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_l      <= 4'd0;
            q_rd      <= 1'b0;
            q_addr    <= 6'd0;
            cmp_valid <= 1'b0;
            cmp_idx   <= 2'd0;
        end else begin
            // Data returns one cycle after the strobe; track which index it belongs to.
            cmp_valid <= q_rd;
            cmp_idx   <= q_addr[1:0];
            if (accept) begin
                st_l <= st;
                if (!pick_rand) begin
                    q_rd   <= 1'b1;
                    q_addr <= {st, 2'd0};
                end
            end else if (state == READ) begin
                if (q_addr[1:0] == 2'd3) q_rd <= 1'b0;
                else                     q_addr <= {st_l, q_addr[1:0] + 2'd1};
            end
        end
    end

    // Running argmax, random-action latch and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            best      <= '0;
            best_a    <= 2'd0;
            act       <= 2'd0;
            act_valid <= 1'b0;
            explore   <= 1'b0;
        end else begin
            if (accept && pick_rand) begin
                best_a <= lfsr[9:8];
            end else if (take) begin
                best   <= $signed(q_data);
                best_a <= cmp_idx;
            end
            act_valid <= finish;
            if (finish) begin
                // The final compare happens in DRAIN, so fold it in via final_a.
                act     <= finish_rand ? best_a : final_a;
                explore <= finish_rand;
            end
        end
    end

    // Linear epsilon decay with floor; computed in 9 bits to avoid wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            epsilon <= EPS_INIT;
        end else if (episode_done) begin
            if ({1'b0, epsilon} < ({1'b0, EPS_MIN} + {1'b0, EPS_DEC})) epsilon <= EPS_MIN;
            else                                                       epsilon <= epsilon - EPS_DEC;
        end
    end

endmodule

// File: tb/tb_dqn_action_selector.sv
// Scoreboard bench for dqn_action_selector. Three instances with different
// EPS_INIT share clock, reset and a Q-table model; only one is exercised at a time.
// Inst 0: EPS_INIT=0 (always exploit), inst 1: 255 (mostly explore), inst 2: 40 (decay).
module tb_dqn_action_selector;

    typedef struct {
        int         inst;
        logic [1:0] act;
        logic       explore;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  st;
    logic [2:0]  start_w;
    logic [2:0]  ep_w;
    logic [2:0]  q_rd_w;
    logic [2:0]  act_valid_w;
    logic [2:0]  explore_w;
    logic [2:0]  busy_w;
    logic [5:0]  q_addr_w   [3];
    logic [15:0] q_data_w   [3];
    logic [1:0]  act_w      [3];
    logic [7:0]  epsilon_w  [3];

    logic [15:0] qmem [64];
    logic [15:0] tb_lfsr = 16'hACE1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          qrd_cnt [3] = '{0, 0, 0};
    exp_t        sb [$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    dqn_action_selector #(.QW(16), .EPS_INIT(8'd0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .st(st), .episode_done(ep_w[0]),
        .q_rd(q_rd_w[0]), .q_addr(q_addr_w[0]), .q_data(q_data_w[0]), .act(act_w[0]),
        .act_valid(act_valid_w[0]), .explore(explore_w[0]), .busy(busy_w[0]), .epsilon(epsilon_w[0]));

    dqn_action_selector #(.QW(16), .EPS_INIT(8'd255)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .st(st), .episode_done(ep_w[1]),
        .q_rd(q_rd_w[1]), .q_addr(q_addr_w[1]), .q_data(q_data_w[1]), .act(act_w[1]),
        .act_valid(act_valid_w[1]), .explore(explore_w[1]), .busy(busy_w[1]), .epsilon(epsilon_w[1]));

    dqn_action_selector #(.QW(16), .EPS_INIT(8'd40)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .st(st), .episode_done(ep_w[2]),
        .q_rd(q_rd_w[2]), .q_addr(q_addr_w[2]), .q_data(q_data_w[2]), .act(act_w[2]),
        .act_valid(act_valid_w[2]), .explore(explore_w[2]), .busy(busy_w[2]), .epsilon(epsilon_w[2]));

    // Cycle counter and reference LFSR written from the polynomial.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) tb_lfsr <= 16'hACE1;
        else     tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    // Q-table model: data valid one cycle after the address.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) q_data_w[i] <= qmem[q_addr_w[i]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every act_valid from any instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (q_rd_w[i] === 1'b1) qrd_cnt[i]++;
            if (act_valid_w[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_act_valid: inst %0d at cycle %0d, expected none", i, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("valid_inst",  i,            mon_e.inst);
                    check("act",         act_w[i],     mon_e.act);
                    check("explore",     explore_w[i], mon_e.explore);
                    check("valid_cycle", cyc,          mon_e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input logic [1:0] a, input logic ex, input int at);
        exp_t e;
        e.inst    = inst;
        e.act     = a;
        e.explore = ex;
        e.cyc     = at;
        sb.push_back(e);
    endtask

    task automatic set_q(input int base, input int v0, input int v1, input int v2, input int v3);
        qmem[base]     = 16'(v0);
        qmem[base + 1] = 16'(v1);
        qmem[base + 2] = 16'(v2);
        qmem[base + 3] = 16'(v3);
    endtask

    // One selection on one instance, then idle long enough for it to finish.
    task automatic run_sel(input int inst, input logic [3:0] s, input logic [1:0] a, input logic ex);
        start_w[inst] = 1'b1;
        st            = s;
        push(inst, a, ex, cyc + (ex ? 2 : 6));
        tick();
        start_w[inst] = 1'b0;
        repeat (7) tick();
    endtask

    task automatic pulse_ep(input int inst, input logic [7:0] want, input string name);
        ep_w[inst] = 1'b1;
        tick();
        ep_w[inst] = 1'b0;
        @(negedge clk);
        check(name, epsilon_w[inst], want);
    endtask

    initial begin
        int c;
        int n;
        for (int i = 0; i < 64; i++) qmem[i] = 16'd0;
        rst     = 1'b1;
        st      = 4'd0;
        start_w = 3'b000;
        ep_w    = 3'b000;
        repeat (3) tick();

        // Reset state of every instance.
        @(negedge clk);
        check("rst_busy",      {29'd0, busy_w},      32'd0);
        check("rst_q_rd",      {29'd0, q_rd_w},      32'd0);
        check("rst_act_valid", {29'd0, act_valid_w}, 32'd0);
        check("rst_explore",   {29'd0, explore_w},   32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rst_act",    act_w[i],    0);
            check("rst_q_addr", q_addr_w[i], 0);
        end
        check("rst_eps0", epsilon_w[0], 0);
        check("rst_eps1", epsilon_w[1], 255);
        check("rst_eps2", epsilon_w[2], 40);
        tick();

        // Explore in the first cycle out of reset: seed 16'hACE1, low byte 225 < 255, bits 9:8 = 0.
        rst           = 1'b0;
        start_w[1]    = 1'b1;
        st            = 4'd5;
        push(1, 2'd0, 1'b1, cyc + 2);
        tick();
        start_w[1]    = 1'b0;
        repeat (5) tick();
        check("explore_no_q_rd", qrd_cnt[1], 0);

        // Exploit argmax with cycle-accurate read sequence and busy window.
        set_q(20, 10, -3, 42, 7);
        c          = cyc;
        start_w[0] = 1'b1;
        st         = 4'd5;
        push(0, 2'd2, 1'b0, c + 6);
        for (int k = 1; k <= 6; k++) begin
            tick();
            start_w[0] = 1'b0;
            @(negedge clk);
            check($sformatf("busy_c%0d", k), busy_w[0], (k <= 5) ? 1 : 0);
            check($sformatf("q_rd_c%0d", k), q_rd_w[0], (k <= 4) ? 1 : 0);
            if (k <= 5) check($sformatf("q_addr_c%0d", k), q_addr_w[0], (k <= 4) ? 19 + k : 23);
        end
        repeat (2) tick();

        // Ties resolve low, negatives, signed extremes, last-index and all-equal cases.
        set_q(4,  5, 9, 9, 1);
        run_sel(0, 4'd1, 2'd1, 1'b0);
        set_q(36, -8, -2, -2, -100);
        run_sel(0, 4'd9, 2'd1, 1'b0);
        set_q(8,  -5, -5, -5, -4);
        run_sel(0, 4'd2, 2'd3, 1'b0);
        set_q(12, 7, 7, 7, 7);
        run_sel(0, 4'd3, 2'd0, 1'b0);
        set_q(16, -32768, 32767, 0, -1);
        run_sel(0, 4'd4, 2'd1, 1'b0);

        // Busy: starts in cycles 2..5 ignored, start in the act_valid cycle accepted.
        c          = cyc;
        start_w[0] = 1'b1;
        st         = 4'd5;
        push(0, 2'd2, 1'b0, c + 6);
        tick();
        start_w[0] = 1'b0;
        tick();
        start_w[0] = 1'b1;
        st         = 4'd1;
        repeat (4) tick();
        push(0, 2'd1, 1'b0, c + 12);
        tick();
        start_w[0] = 1'b0;
        repeat (8) tick();

        // Epsilon decay on inst 2; the second pulse coincides with a start whose
        // LFSR byte lies between the new and old epsilon, so only the old value explores.
        pulse_ep(2, 8'd32, "eps_pulse1");
        tick();
        for (n = 0; n < 4000 && !(tb_lfsr[7:0] >= 8'd24 && tb_lfsr[7:0] < 8'd32); n++) tick();
        check("eps_window_found", (n < 4000) ? 1 : 0, 1);
        start_w[2] = 1'b1;
        st         = 4'd5;
        push(2, tb_lfsr[9:8], 1'b1, cyc + 2);
        ep_w[2]    = 1'b1;
        tick();
        start_w[2] = 1'b0;
        ep_w[2]    = 1'b0;
        @(negedge clk);
        check("eps_pulse2", epsilon_w[2], 24);
        repeat (4) tick();
        pulse_ep(2, 8'd16, "eps_pulse3");
        tick();
        pulse_ep(2, 8'd16, "eps_pulse4_floor");
        tick();

        // epsilon=255 exploits only when the LFSR byte is 8'hFF.
        for (n = 0; n < 4000 && tb_lfsr[7:0] != 8'hFF; n++) tick();
        check("lfsr_ff_found", (n < 4000) ? 1 : 0, 1);
        run_sel(1, 4'd5, 2'd2, 1'b0);
        if (tb_lfsr[7:0] == 8'hFF) tick();
        run_sel(1, 4'd9, tb_lfsr[9:8], 1'b1);
        check("q_rd_count_inst1", qrd_cnt[1], 4);

        // Reset in cycle 3 of an exploit selection aborts it with no act_valid.
        start_w[0] = 1'b1;
        st         = 4'd5;
        tick();
        start_w[0] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_busy",    busy_w[0],    0);
        check("midrst_q_rd",    q_rd_w[0],    0);
        check("midrst_q_addr",  q_addr_w[0],  0);
        check("midrst_act",     act_w[0],     0);
        check("midrst_eps0",    epsilon_w[0], 0);
        check("midrst_eps2",    epsilon_w[2], 40);
        check("midrst_explore", explore_w[1], 0);
        tick();
        rst = 1'b0;
        repeat (12) tick();

        // Any expected result still queued never arrived.
        for (n = 0; n < 20 && sb.size() > 0; n++) tick();
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_act_valid: inst %0d expected at cycle %0d, never arrived", mon_e.inst, mon_e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dqn_action_selector.md
Name: dqn_action_selector

Overview:
- Epsilon-greedy action selector for the 3x3 grid-world DQN datapath; sits directly upstream of the grid state-transition stage and supplies its 2-bit action (0 right, 1 up, 2 left, 3 down).
- For the current state, either draws a random action (explore) or reads four Q-values from the Q-table and returns the argmax (exploit).
- Epsilon decays linearly on each episode boundary.

Parameters:
- QW, 16, Q-value width; Q-values are two's-complement signed.
- EPS_INIT, 8'd255, epsilon after reset, on a 0..255 scale.
- EPS_MIN, 8'd16, floor for epsilon.
- EPS_DEC, 8'd8, amount subtracted from epsilon per episode_done.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request an action for st; accepted only when busy=0
- st  in  4  current grid state, 1..9; caller guarantees range
- episode_done  in  1  one-cycle pulse; decays epsilon
- q_rd  out  1  Q-table read strobe
- q_addr  out  6  Q-table address = {st_latched, a} = st*4+a
- q_data  in  QW  Q-value; valid exactly one cycle after the q_rd cycle
- act  out  2  selected action; held until next act_valid
- act_valid  out  1  one-cycle pulse; act is valid in this cycle
- explore  out  1  1 if the last act was random; updated with act
- busy  out  1  high while a selection is in flight
- epsilon  out  8  current epsilon

Behaviour:
- Reset values: act=0, act_valid=0, explore=0, busy=0, q_rd=0, q_addr=0, epsilon=EPS_INIT, LFSR=16'hACE1, FSM=IDLE.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts left each cycle; new bit0 = b15^b13^b12^b10.
  - Advances every cycle rst=0 and holds the seed during reset.
- FSM states: IDLE, EXPL, READ, DRAIN, DONE. busy = (state != IDLE).
- IDLE:
  - On start, latch st.
  - If LFSR[7:0] < epsilon (unsigned, current-cycle values): go to EXPL and latch act_next=LFSR[9:8].
  - Otherwise go to READ with a=0.
- EXPL: one cycle, then go to DONE with explore_next=1. No q_rd is issued.
- READ:
  - Cycles 1..4 after start: q_rd=1, q_addr={st_l, a} for a=0,1,2,3 in order.
  - After a=3, go to DRAIN.
- Compare:
  - Each q_data (cycles 2..5) is compared signed against the running best.
  - a=0 loads the best unconditionally.
  - Later a replaces the best only on strict greater-than, so ties resolve to the lowest index.
- DRAIN: cycle 5; the last compare completes. Go to DONE with explore_next=0.
- DONE:
  - act, explore and act_valid=1 are registered on entry.
  - Returns to IDLE on the same edge, so act_valid is high in the first IDLE cycle.
  - Net effect: act_valid occurs 2 cycles after the start cycle for explore, 6 cycles after for exploit.
  - start is accepted in the act_valid cycle.
- start while busy: ignored, with no effect on st latch, LFSR or FSM.
- Epsilon on episode_done:
  - Computed in 9 bits: if epsilon < EPS_MIN + EPS_DEC then epsilon = EPS_MIN, else epsilon = epsilon - EPS_DEC.
  - Applies regardless of busy.
  - If episode_done coincides with an accepted start, the decision uses the pre-decay epsilon.
  - EPS_INIT < EPS_MIN clamps to EPS_MIN on the first pulse.
- epsilon=0: always exploit. LFSR[7:0] < 255 fails only for 8'hFF.
- rst mid-operation: aborts the selection; all outputs return to reset values next cycle; no act_valid is produced.
- q_rd is low outside READ. q_addr holds its last value when q_rd=0.

Test Plan:
- Exploit argmax:
  - Stimulus: EPS_INIT=0, start with st=5, Q[20..23]={10,-3,42,7}.
  - Response: q_addr 20,21,22,23 in cycles 1..4; act=2, explore=0, act_valid in cycle 6; busy high cycles 1..5.
- Tie and negative values:
  - Stimulus: EPS_INIT=0, st=1, Q[4..7]={5,9,9,1}; then st=9, Q[36..39]={-8,-2,-2,-100}.
  - Response: act=1 for both.
- Explore path:
  - Stimulus: EPS_INIT=255, start in the first cycle after rst falls (LFSR=16'hACE1, low byte 225 < 255).
  - Response: explore=1, act=0 (bits 9:8), act_valid in cycle 2, q_rd never asserted.
- Epsilon decay and floor:
  - Stimulus: EPS_INIT=40, four episode_done pulses.
  - Response: epsilon 32, 24, 16, 16. A pulse coinciding with start uses the old value.
- Busy/back-to-back:
  - Stimulus: start again in cycles 2..5 of an exploit selection; start again in the act_valid cycle.
  - Response: the early starts are ignored with one act_valid; the act_valid-cycle start is accepted, with the second act_valid 6 cycles later.
- Reset mid-op:
  - Stimulus: assert rst in cycle 3 of an exploit selection.
  - Response: next cycle busy=0, q_rd=0, act=0, epsilon=EPS_INIT; no act_valid follows.
